// File: rtl/keypad_emu_pkg.sv
// Shared keypad definitions: FSM state codes, key position type and the
// 4x4 layout lookup tables (also used by the scanner side).
package keypad_emu_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t PRESS = 2'd1;
  localparam state_t GAP   = 2'd2;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  // Indexed by key value 0..F. Layout: r0 1 2 3 A / r1 4 5 6 B / r2 7 8 9 C / r3 0 F E D
  localparam logic [1:0] KEY_ROW [16] = '{
    2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
    2'd2, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3
  };
  localparam logic [1:0] KEY_COL [16] = '{
    2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0,
    2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1
  };

endpackage

// File: rtl/keypad_emu_if.sv
// Keypad emulator bus: word request handshake, status and the matrix lines.
interface keypad_emu_if;
  import keypad_emu_pkg::*;

  logic [15:0]        word;
  logic               word_valid;
  logic               word_ready;
  logic               busy;
  logic [DIGIT_W-1:0] key_code;
  logic               pressing;
  logic               done;
  logic [3:0]         col_n;
  logic [3:0]         row_n;

  modport master (
    output word, word_valid, col_n,
    input  word_ready, busy, key_code, pressing, done, row_n
  );

  modport slave (
    input  word, word_valid, col_n,
    output word_ready, busy, key_code, pressing, done, row_n
  );

endinterface

// File: rtl/keypad_key_map.sv
// Combinational key value -> matrix (row, col) position.
module keypad_key_map
  import keypad_emu_pkg::*;
(
  input  logic [DIGIT_W-1:0] keyCode,
  output key_pos_t           keyPos
);

  assign keyPos.row = KEY_ROW[keyCode];
  assign keyPos.col = KEY_COL[keyCode];

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad responder replaying a 16-bit word as timed key presses.
// Optional contact bounce model enabled by defining KEYPAD_EMU_BOUNCE_EN.
module keypad_emulator
  import keypad_emu_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2_000_000,
  parameter int GAP_CYCLES    = 2_000_000,
  parameter int DIGITS        = 4,
  parameter int BOUNCE_CYCLES = 100_000
) (
  input logic         clk,
  input logic         rst,
  keypad_emu_if.slave bus
);

  localparam int LONGEST_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int LONGEST    = (LONGEST_HG > BOUNCE_CYCLES) ? LONGEST_HG : BOUNCE_CYCLES;
  localparam int CNT_W      = $clog2(LONGEST + 1);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [1:0]       LAST_IDX  = 2'(DIGITS - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         digitIdx;
  logic [15:0]        latchedWord;
  logic               doneReg;
  logic [3:0]         rowReg;
  logic [3:0]         rowNext;
  logic [1:0]         nibSel;
  logic [DIGIT_W-1:0] curNibble;
  logic               contact;
  key_pos_t           keyPos;

  // Digits are replayed most-significant first from word[4*DIGITS-1:0]
  assign nibSel = LAST_IDX - digitIdx;

  always_comb begin
    case (nibSel)
      2'd0:    curNibble = latchedWord[3:0];
      2'd1:    curNibble = latchedWord[7:4];
      2'd2:    curNibble = latchedWord[11:8];
      default: curNibble = latchedWord[15:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      digitIdx    <= '0;
      latchedWord <= '0;
      doneReg     <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.word_valid) begin
            latchedWord <= bus.word;
            digitIdx    <= '0;
            cnt         <= HOLD_LOAD;
            state       <= PRESS;
          end
        end
        PRESS: begin
          if (cnt == '0) begin
            cnt   <= GAP_LOAD;
            state <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            if (digitIdx == LAST_IDX) begin
              doneReg <= 1'b1;
              state   <= IDLE;
            end else begin
              digitIdx <= digitIdx + 1'b1;
              cnt      <= HOLD_LOAD;
              state    <= PRESS;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  // Counter runs down from the reload value, so "early in the state" means a high count
  always_comb begin
    contact = (state == PRESS);
    if (state == PRESS && int'(cnt) >= HOLD_CYCLES - BOUNCE_CYCLES)
      contact = ~cnt[3];
    if (state == GAP && int'(cnt) >= GAP_CYCLES - BOUNCE_CYCLES)
      contact = cnt[3];
  end
`else
  assign contact = (state == PRESS);
`endif

  keypad_key_map uKeyMap (
    .keyCode (curNibble),
    .keyPos  (keyPos)
  );

  // A closed switch ties the key's row to its column, whatever else the scanner drives
  always_comb begin
    rowNext = 4'hF;
    if (contact)
      rowNext[keyPos.row] = bus.col_n[keyPos.col];
  end

  always_ff @(posedge clk) begin
    if (rst)
      rowReg <= 4'hF;
    else
      rowReg <= rowNext;
  end

  assign bus.row_n      = rowReg;
  assign bus.word_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.key_code   = (state == IDLE) ? '0 : curNibble;
  assign bus.pressing   = contact;
  assign bus.done       = doneReg;

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized scoreboard bench for keypad_emulator (HOLD=20, GAP=10, DIGITS=4).
module tb_keypad_emulator;

  localparam int HOLD     = 20;
  localparam int GAP      = 10;
  localparam int DIGITS   = 4;
  localparam int PERIOD   = HOLD + GAP;
  localparam int WORD_LEN = DIGITS * PERIOD;

  typedef struct {
    int     key;
    longint at;
  } press_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  keypad_emu_if ifc ();

  keypad_emulator #(
    .HOLD_CYCLES   (HOLD),
    .GAP_CYCLES    (GAP),
    .DIGITS        (DIGITS),
    .BOUNCE_CYCLES (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  longint cyc = 0;
  logic [3:0] edgeCol = 4'hF;
  longint lastA = -1000;
  logic [15:0] modelWord = 16'h0;
  press_t pressQ[$];
  longint doneQ[$];
  int colMode = 0;
  bit monOn = 0;
  logic prevPress = 1'b0;
  int LAYOUT[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit idleAfter(longint e);
    return (e - lastA) >= WORD_LEN;
  endfunction

  function automatic bit pressAfter(longint e);
    longint d = e - lastA;
    return d >= 0 && d < WORD_LEN && (d % PERIOD) < HOLD;
  endfunction

  function automatic int nibbleOf(logic [15:0] w, longint i);
    logic [15:0] s = w >> (4 * (DIGITS - 1 - i));
    return int'(s[3:0]);
  endfunction

  function automatic int keyAfter(longint e);
    longint d = e - lastA;
    if (d < 0 || d >= WORD_LEN) return 0;
    return nibbleOf(modelWord, d / PERIOD);
  endfunction

  function automatic logic [3:0] rowFor(int key, logic [3:0] col);
    logic [3:0] r = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (LAYOUT[i][j] == key) r[i] = col[j];
    return r;
  endfunction

  always @(posedge clk) begin
    edgeCol <= ifc.col_n;
    cyc     <= cyc + 1;
  end

  // Monitor: per-cycle model comparison plus scoreboard pops on press starts and done
  always @(negedge clk) begin
    if (monOn) begin
      press_t p;
      longint dn;
      check("row_n", ifc.row_n,
            pressAfter(cyc - 1) ? rowFor(keyAfter(cyc - 1), edgeCol) : 4'hF);
      check("word_ready", ifc.word_ready, idleAfter(cyc));
      check("busy", ifc.busy, !idleAfter(cyc));
      check("pressing", ifc.pressing, pressAfter(cyc));
      check("key_code", ifc.key_code, keyAfter(cyc));
      if (ifc.pressing === 1'b1 && prevPress !== 1'b1) begin
        if (pressQ.size() == 0) check("press_unexpected", 1, 0);
        else begin
          p = pressQ.pop_front();
          check("press_key", ifc.key_code, p.key);
          check("press_cycle", cyc, p.at);
        end
      end
      if (ifc.done === 1'b1) begin
        if (doneQ.size() == 0) check("done_unexpected", 1, 0);
        else begin
          dn = doneQ.pop_front();
          check("done_cycle", cyc, dn);
        end
      end
      prevPress <= ifc.pressing;
    end
  end

  task automatic setCol();
    case (colMode)
      0:       ifc.col_n = ~(4'b0001 << (cyc % 4));
      1:       ifc.col_n = 4'($urandom);
      default: ifc.col_n = 4'h0;
    endcase
  endtask

  task automatic acceptModel(input logic [15:0] w);
    lastA     = cyc + 1;
    modelWord = w;
    for (int i = 0; i < DIGITS; i++)
      pressQ.push_back('{nibbleOf(w, i), lastA + i * PERIOD});
    doneQ.push_back(lastA + WORD_LEN);
  endtask

  task automatic stepIdle(input bit r);
    @(negedge clk);
    #1;
    setCol();
    rst            = r;
    ifc.word_valid = 1'b0;
    ifc.word       = 16'h0;
    if (r) begin
      lastA = -1000;
      pressQ.delete();
      doneQ.delete();
    end
  endtask

  // Offers w as soon as the model is idle; while busy, drives ignored FFFF noise
  task automatic playWord(input logic [15:0] w);
    bit acc = 0;
    for (int n = 0; n < 4 * WORD_LEN && !acc; n++) begin
      @(negedge clk);
      #1;
      setCol();
      rst = 1'b0;
      if (idleAfter(cyc)) begin
        ifc.word_valid = 1'b1;
        ifc.word       = w;
        acceptModel(w);
        acc = 1;
      end else begin
        ifc.word_valid = 1'($urandom_range(0, 1));
        ifc.word       = 16'hFFFF;
      end
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  initial begin
    ifc.word_valid = 1'b0;
    ifc.word       = 16'h0;
    ifc.col_n      = 4'hF;
    @(posedge clk);
    monOn = 1;
    repeat (3) stepIdle(1'b1);
    stepIdle(1'b0);
    check("reset_row_n", ifc.row_n, 4'hF);
    check("reset_word_ready", ifc.word_ready, 1);
    check("reset_busy", ifc.busy, 0);
    check("reset_done", ifc.done, 0);
    check("reset_key_code", ifc.key_code, 0);

    colMode = 0;
    playWord(16'h1A05);
    playWord(16'h1A05);

    colMode = 2;
    playWord(16'h1A05);
    while (cyc < lastA + 94) stepIdle(1'b0);
    stepIdle(1'b1);
    @(negedge clk);
    check("rst_mid_press_row_n", ifc.row_n, 4'hF);
    colMode = 0;
    playWord(16'h0000);

    for (int i = 0; i < 6; i++) begin
      colMode = $urandom_range(0, 2);
      playWord(16'($urandom));
    end

    for (int n = 0; n < WORD_LEN + 10; n++) stepIdle(1'b0);
    check("press_queue_drained", pressQ.size(), 0);
    check("done_queue_drained", doneQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
